// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage register.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Provides the stage state encoding and the default payload constants
// (MIPS NOP for bubbles, PC reset vector for the PC stage).

package pipe_stage_reg_pkg;

    // Occupancy states of the stage: 0, 1 or 2 held entries.
    typedef enum logic [1:0] {
        PSR_EMPTY = 2'd0,
        PSR_FULL  = 2'd1,
        PSR_SKID  = 2'd2
    } psr_state_t;

    // Bubble payload: the all-zero word decodes as sll $0,$0,0 (NOP).
    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    // Reset value of the PC stage.
    localparam logic [31:0] PC_RESET = 32'h0000_3000;

    // Number of valid entries held in a given state.
    function automatic logic [1:0] psr_occupancy(input psr_state_t s);
        case (s)
            PSR_FULL: psr_occupancy = 2'd1;
            PSR_SKID: psr_occupancy = 2'd2;
            default:  psr_occupancy = 2'd0;
        endcase
    endfunction

endpackage : pipe_stage_reg_pkg

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with enable and synchronous active-high reset.
// Latency: count visible one cycle after the enabled edge.
// Backpressure: none; stops at all-ones instead of wrapping.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high clear
//   en   - count this cycle
//   cnt  - current count (WIDTH bits)

module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max = &r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (en && !w_at_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule : sat_counter

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and 2-entry skid buffer.
// Latency: 1 cycle in_data -> out_data; full throughput when out_ready stays high.
// Backpressure: in_ready is registered-state only (no path from out_ready); the
//               skid entry absorbs the one extra beat accepted while stalling.
//
// Optional feature: define PIPE_STAGE_STALL_CNT_EN to add the stall_cnt port,
// a saturating count of cycles with out_valid && !out_ready.
//
// Ports:
//   clk        - clock, all state updates on its rising edge
//   rst        - synchronous active-high reset (beats flush and handshakes)
//   flush      - drop all held entries, present BUBBLE_VAL on out_data
//   in_valid   - upstream offers in_data
//   in_ready   - stage can accept this cycle
//   in_data    - upstream payload
//   out_valid  - out_data holds a valid entry
//   out_ready  - downstream accepts out_data this cycle
//   out_data   - payload of the head entry
//   stall_cnt  - stall cycle count (PIPE_STAGE_STALL_CNT_EN only)

module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int          WIDTH      = 32,
    parameter logic [31:0] RESET_VAL  = PC_RESET,
    parameter logic [31:0] BUBBLE_VAL = MIPS_NOP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef PIPE_STAGE_STALL_CNT_EN
    output logic [31:0]      stall_cnt,
`endif
    output logic [WIDTH-1:0] out_data
);

    // Constants resized to the payload width (truncate or zero-extend).
    localparam logic [WIDTH-1:0] W_RESET_V  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] W_BUBBLE_V = WIDTH'(BUBBLE_VAL);

    psr_state_t       r_state;
    psr_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;

    // ------------------------------------------------------------------
    // State and payload registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PSR_EMPTY;
            r_main  <= W_RESET_V;
            r_skid  <= W_BUBBLE_V;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and payload steering
    // ------------------------------------------------------------------
    // in_ready is implied by the state here: EMPTY and FULL always accept,
    // SKID never does, so in_valid alone marks an input transfer.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;

        case (r_state)
            PSR_EMPTY: begin
                if (in_valid) begin
                    w_main_nxt  = in_data;
                    w_state_nxt = PSR_FULL;
                end
            end

            PSR_FULL: begin
                if (out_ready && in_valid) begin
                    w_main_nxt  = in_data;
                end else if (out_ready) begin
                    // Drained: out_data keeps showing the consumed word.
                    w_state_nxt = PSR_EMPTY;
                end else if (in_valid) begin
                    // Downstream stalled but we already advertised ready:
                    // park the beat in the skid entry.
                    w_skid_nxt  = in_data;
                    w_state_nxt = PSR_SKID;
                end
            end

            PSR_SKID: begin
                if (out_ready) begin
                    w_main_nxt  = r_skid;
                    w_state_nxt = PSR_FULL;
                end
            end

            default: begin
                w_state_nxt = PSR_EMPTY;
            end
        endcase

        // Flush wins over any handshake in the same cycle; an input beat
        // presented alongside it is lost by design.
        if (flush) begin
            w_state_nxt = PSR_EMPTY;
            w_main_nxt  = W_BUBBLE_V;
            w_skid_nxt  = r_skid;
        end
    end

    // ------------------------------------------------------------------
    // Handshake outputs (decoded from registered state only)
    // ------------------------------------------------------------------
    assign out_valid = (psr_occupancy(r_state) != 2'd0);
    assign in_ready  = (r_state != PSR_SKID) && !rst;
    assign out_data  = r_main;

`ifdef PIPE_STAGE_STALL_CNT_EN
    // ------------------------------------------------------------------
    // Stall counter: cycles where a valid head waits on downstream.
    // Only rst clears it so flushes do not hide stall history.
    // ------------------------------------------------------------------
    logic w_stall;

    assign w_stall = out_valid && !out_ready;

    sat_counter #(
        .WIDTH (32)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (w_stall),
        .cnt (stall_cnt)
    );
`endif

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed steps followed by random
// traffic, all compared against a 2-deep FIFO reference model.
// Ends with one summary line.

module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .WIDTH      (32),
        .RESET_VAL  (32'h0000_3000),
        .BUBBLE_VAL (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PIPE_STAGE_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .out_data  (out_data)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a FIFO of capacity 2 plus the word last shown.
    logic [31:0] mq[$];
    logic [31:0] last_out;
    logic [31:0] exp_stall;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check pre-edge outputs, clock, advance model.
    task automatic cyc(input logic r, input logic f, input logic iv,
                       input logic [31:0] d, input logic ordy);
        logic exp_rdy;
        logic exp_vld;
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        exp_rdy = (mq.size() < 2) && !r;
        exp_vld = (mq.size() > 0);
        chk1("in_ready", in_ready, exp_rdy);
        chk1("out_valid", out_valid, exp_vld);
        chk32("out_data", out_data, last_out);
`ifdef PIPE_STAGE_STALL_CNT_EN
        chk32("stall_cnt", stall_cnt, exp_stall);
`endif
        @(posedge clk);
        if (r) begin
            mq.delete();
            last_out  = PC_RESET;
            exp_stall = 32'd0;
        end else begin
            if (exp_vld && !ordy && exp_stall != 32'hFFFF_FFFF) exp_stall++;
            if (f) begin
                mq.delete();
                last_out = MIPS_NOP;
            end else begin
                if (exp_vld && ordy) void'(mq.pop_front());
                if (iv && exp_rdy) mq.push_back(d);
                if (mq.size() > 0) last_out = mq[0];
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mq.delete();
        last_out  = PC_RESET;
        exp_stall = 32'd0;
        chk1("in_ready_in_rst", in_ready, 1'b0);

        // Reset release
        cyc(0, 0, 0, 32'd0, 1);
        chk32("reset_pc", out_data, 32'h0000_3000);

        // Streaming 1..4 at full rate
        for (int i = 1; i <= 4; i++) cyc(0, 0, 1, 32'(i), 1);
        cyc(0, 0, 0, 32'd0, 1);
        cyc(0, 0, 0, 32'd0, 1);

        // Backpressure: A then B with out_ready low, then drain
        cyc(0, 0, 1, 32'hAAAA_0001, 0);
        cyc(0, 0, 1, 32'hBBBB_0002, 0);
        cyc(0, 0, 1, 32'hDEAD_BEEF, 0);   // refused, stage is in SKID
        cyc(0, 0, 0, 32'd0, 1);
        cyc(0, 0, 0, 32'd0, 1);
        cyc(0, 0, 0, 32'd0, 1);

        // Flush while holding two entries, with a competing input beat
        cyc(0, 0, 1, 32'hAAAA_0011, 0);
        cyc(0, 0, 1, 32'hBBBB_0022, 0);
        cyc(0, 1, 1, 32'hCCCC_0033, 0);
        chk32("flush_bubble", out_data, 32'h0000_0000);
        cyc(0, 0, 1, 32'hDDDD_0044, 0);
        chk32("d_after_flush", out_data, 32'hDDDD_0044);
        cyc(0, 0, 0, 32'd0, 1);
        cyc(0, 0, 0, 32'd0, 1);

        // Reset mid-operation with two entries held
        cyc(0, 0, 1, 32'hAAAA_0101, 0);
        cyc(0, 0, 1, 32'hBBBB_0202, 0);
        cyc(1, 0, 0, 32'd0, 1);
        chk32("midrst_pc", out_data, 32'h0000_3000);
        cyc(0, 0, 0, 32'd0, 1);
        cyc(0, 0, 0, 32'd0, 1);

`ifdef PIPE_STAGE_STALL_CNT_EN
        // Stall counting and saturation
        cyc(1, 0, 0, 32'd0, 0);
        cyc(0, 0, 1, 32'h1234_5678, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 32'd0, 0);
        chk32("stall_10", stall_cnt, 32'd10);
        dut.u_stall_cnt.r_cnt = 32'hFFFF_FFFE;
        exp_stall = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 32'd0, 0);
        chk32("stall_sat", stall_cnt, 32'hFFFF_FFFF);
        cyc(0, 0, 0, 32'd0, 1);
`endif

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 3) != 0),
                $urandom,
                ($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_pipe_stage_reg

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register for the Sample MIPS datapath, used for the IF/ID, ID/EX, EX/MEM and MEM/WB boundaries and for the PC stage.
- Replaces plain enable registers with a valid/ready handshake and a 2-entry skid buffer, so downstream backpressure never drops or duplicates data.
- Adds a flush that inserts a bubble, plus a programmable reset value (for example 32'h0000_3000 for the PC).

Parameters:
- WIDTH, 32, payload width in bits.
- RESET_VAL, 32'h0000_3000, value of out_data after reset; truncated or zero-extended to WIDTH.
- BUBBLE_VAL, 32'h0000_0000, value of out_data after a flush (the MIPS NOP encoding); truncated or zero-extended to WIDTH.

Ports:
- clk  in  1  clock; all state updates on the codebase's clk_trigger_edge of clk.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries and insert a bubble.
- in_valid  in  1  upstream has data on in_data.
- in_ready  out  1  stage can accept data this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data holds a valid entry.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  WIDTH  payload of the head entry.
- stall_cnt  out  32  present only with STALL_CNT_EN.

Behaviour:
- Storage:
  - Main register main_q (drives out_data) and skid register skid_q.
  - State encoding: EMPTY (no valid entry), FULL (main valid), SKID (main and skid valid).
- Handshake:
  - A transfer in occurs when in_valid && in_ready; a transfer out occurs when out_valid && out_ready.
  - out_valid = (state != EMPTY), decoded from registered state only.
  - in_ready = (state != SKID) && !rst. It has no combinational path from out_ready.
- Reset (rst sampled high at the clock edge):
  - state <= EMPTY, main_q <= RESET_VAL, skid_q <= BUBBLE_VAL.
  - Afterwards out_valid=0, in_ready=1, out_data=RESET_VAL.
  - Reset overrides flush and all handshakes; reset mid-operation discards both entries.
- Flush (flush=1, rst=0):
  - Next state EMPTY, main_q <= BUBBLE_VAL.
  - Flush takes priority: an input transfer presented in the same cycle is discarded, and upstream must treat it as lost.
- Transitions when rst=0 and flush=0:
  - EMPTY, in_valid: main_q <= in_data, go to FULL. Latency is 1 cycle from in_data to out_data/out_valid.
  - EMPTY, !in_valid: stay in EMPTY; out_data holds its last value.
  - FULL, out_ready && in_valid: main_q <= in_data, stay in FULL. This is full throughput, one entry per cycle.
  - FULL, out_ready && !in_valid: go to EMPTY; out_data keeps the drained value.
  - FULL, !out_ready && in_valid: skid_q <= in_data, go to SKID. in_ready drops the next cycle.
  - FULL, neither: hold.
  - SKID, out_ready: main_q <= skid_q, go to FULL. No input is accepted this cycle.
  - SKID, !out_ready: hold.
- Ordering and width:
  - Strict FIFO order; occupancy never exceeds 2.
  - No data is ever overwritten while valid and unconsumed.
  - No arithmetic on the payload.

Optional Feature:
- Macro: PIPE_STAGE_STALL_CNT_EN.
- Defined:
  - stall_cnt counts cycles with out_valid && !out_ready.
  - Increments by 1 per such cycle and saturates at 32'hFFFF_FFFF.
  - Cleared by rst only; flush does not clear it.
  - The port and counter logic exist only when the macro is defined.
- Undefined:
  - The stall_cnt port is absent and no counter logic is generated.
  - Handshake behaviour is identical.

Decomposition:
- Shared package or include file (alongside define.v):
  - State encoding constants PSR_EMPTY=2'd0, PSR_FULL=2'd1, PSR_SKID=2'd2.
  - Default NOP constant MIPS_NOP=32'h0000_0000.
  - Default PC reset constant PC_RESET=32'h0000_3000.
- One natural sub-module: sat_counter (WIDTH-parametrised saturating counter with enable and synchronous reset), instantiated only under PIPE_STAGE_STALL_CNT_EN.

Test Plan:
- Reset release: rst=1 for 2 cycles, then 0 -> out_valid=0, in_ready=1, out_data=32'h0000_3000.
- Streaming: out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each, out_valid=1 throughout, in_ready=1 throughout.
- Backpressure:
  - Send A then B with out_ready=0 -> state SKID, in_ready=0, out_data=A.
  - Raise out_ready -> A consumed, then B consumed the next cycle, no loss.
- Flush in SKID:
  - Flush with in_valid=1, in_data=C -> next cycle out_valid=0, out_data=32'h0, C never appears.
  - Send D -> D emerges after 1 cycle.
- Reset mid-operation: in SKID holding A and B, pulse rst -> out_valid=0, out_data=32'h0000_3000, A and B never emitted.
- STALL_CNT_EN: hold out_valid=1 with out_ready=0 for 10 cycles -> stall_cnt=10; force the counter to 32'hFFFF_FFFE and stall 3 cycles -> stall_cnt=32'hFFFF_FFFF.
